// File: rtl/rbm_sample_accumulator_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rbm_sample_accumulator_pkg
// Brief    : Shared constants, FSM encodings and width helpers for the
//            RBM sample accumulator.
// Revision : 1.0 - initial release
// ============================================================================
package rbm_sample_accumulator_pkg;

    typedef logic [1:0] state_t;

    localparam state_t c_ST_IDLE  = 2'd0;
    localparam state_t c_ST_ACCUM = 2'd1;
    localparam state_t c_ST_SCAN  = 2'd2;
    localparam state_t c_ST_DONE  = 2'd3;

    // Ceiling log2 for elaboration-time width derivation; clog2(1) is 0.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

    function automatic int max1(input int value);
        return (value < 1) ? 1 : value;
    endfunction

endpackage : rbm_sample_accumulator_pkg
`default_nettype wire

// File: rtl/rbm_argmax_scan.sv
`default_nettype none
// ============================================================================
// Module   : rbm_argmax_scan
// Brief    : Sequential compare/hold unit; tracks the largest value seen and
//            its index. Strict compare keeps the lower index on ties.
// Revision : 1.0 - initial release
// ============================================================================
module rbm_argmax_scan #(
    parameter int VAL_BW = 14,
    parameter int IDX_BW = 3
) (
    input  logic              clock_i,
    input  logic              reset_ni,
    input  logic              clear_i,
    input  logic              en_i,
    input  logic [VAL_BW-1:0] value_i,
    input  logic [IDX_BW-1:0] idx_i,
    output logic [VAL_BW-1:0] best_o,
    output logic [IDX_BW-1:0] best_idx_o
);

    logic [VAL_BW-1:0] best_q;
    logic [IDX_BW-1:0] best_idx_q;

    always_ff @(posedge clock_i) begin
        if (!reset_ni || clear_i) begin
            best_q     <= '0;
            best_idx_q <= '0;
        end else if (en_i && (value_i > best_q)) begin
            best_q     <= value_i;
            best_idx_q <= idx_i;
        end
    end

    assign best_o     = best_q;
    assign best_idx_o = best_idx_q;

endmodule : rbm_argmax_scan
`default_nettype wire

// File: rtl/rbm_sample_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : rbm_sample_accumulator
// Brief    : Accumulates NUM_SAMPLES hidden-unit vectors, then scans for the
//            most active unit and holds the result behind valid/ready.
// Revision : 1.0 - initial release
// ============================================================================
module rbm_sample_accumulator
    import rbm_sample_accumulator_pkg::*;
#(
    parameter  int OUTPUT_BITLENGTH = 12,
    parameter  int OUT_DIM          = 5,
    parameter  int NUM_SAMPLES      = 4,
    localparam int ACC_BW           = OUTPUT_BITLENGTH + clog2(NUM_SAMPLES),
    localparam int IDX_BW           = max1(clog2(OUT_DIM)),
    localparam int CNT_BW           = clog2(NUM_SAMPLES + 1)
) (
    input  logic                                clock_i,
    input  logic                                reset_ni,
    input  logic                                start_i,
    input  logic                                in_valid_i,
    input  logic [OUT_DIM*OUTPUT_BITLENGTH-1:0] in_data_i,
    input  logic                                out_ready_i,
    output logic                                busy_o,
    output logic                                out_valid_o,
    output logic [IDX_BW-1:0]                   class_idx_o,
    output logic [ACC_BW-1:0]                   best_sum_o,
    output logic [OUT_DIM*ACC_BW-1:0]           acc_out_o
);

    localparam logic [CNT_BW-1:0] c_CNT_LAST = CNT_BW'(NUM_SAMPLES - 1);
    localparam logic [IDX_BW-1:0] c_IDX_LAST = IDX_BW'(OUT_DIM - 1);

    state_t              state_q, state_d;
    logic [CNT_BW-1:0]   count_q;
    logic [IDX_BW-1:0]   scan_idx_q;
    logic [ACC_BW-1:0]   acc_q [OUT_DIM];
    logic                busy_q;
    logic                out_valid_q;
    logic [IDX_BW-1:0]   class_idx_q;
    logic [ACC_BW-1:0]   best_sum_q;

    logic                w_acc_clear;
    logic                w_acc_en;
    logic                w_last_sample;
    logic                w_scan_en;
    logic                w_latch;
    logic                w_handshake;
    logic [ACC_BW-1:0]   w_scan_val;
    logic [ACC_BW-1:0]   w_best;
    logic [IDX_BW-1:0]   w_best_idx;
    logic                w_take;

    always_ff @(posedge clock_i) begin
        if (!reset_ni) begin
            state_q <= c_ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            c_ST_IDLE:  if (start_i)                    state_d = c_ST_ACCUM;
            c_ST_ACCUM: if (w_last_sample)              state_d = c_ST_SCAN;
            c_ST_SCAN:  if (scan_idx_q == c_IDX_LAST)   state_d = c_ST_DONE;
            c_ST_DONE:  if (out_valid_q && out_ready_i) state_d = c_ST_IDLE;
            default:                                    state_d = c_ST_IDLE;
        endcase
    end

    always_comb begin
        w_acc_clear   = (state_q == c_ST_IDLE) && start_i;
        w_acc_en      = (state_q == c_ST_ACCUM) && in_valid_i;
        w_last_sample = w_acc_en && (count_q == c_CNT_LAST);
        w_scan_en     = (state_q == c_ST_SCAN);
        w_latch       = w_scan_en && (scan_idx_q == c_IDX_LAST);
        w_handshake   = (state_q == c_ST_DONE) && out_valid_q && out_ready_i;
    end

    assign w_scan_val = acc_q[scan_idx_q];

    rbm_argmax_scan #(
        .VAL_BW (ACC_BW),
        .IDX_BW (IDX_BW)
    ) u_scan (
        .clock_i    (clock_i),
        .reset_ni   (reset_ni),
        .clear_i    (w_last_sample),
        .en_i       (w_scan_en),
        .value_i    (w_scan_val),
        .idx_i      (scan_idx_q),
        .best_o     (w_best),
        .best_idx_o (w_best_idx)
    );

    // The final unit is compared in the same edge that publishes the result.
    assign w_take = w_scan_val > w_best;

    always_ff @(posedge clock_i) begin
        if (!reset_ni) begin
            count_q     <= '0;
            scan_idx_q  <= '0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            class_idx_q <= '0;
            best_sum_q  <= '0;
            for (int i = 0; i < OUT_DIM; i++) begin
                acc_q[i] <= '0;
            end
        end else begin
            busy_q <= (state_d == c_ST_ACCUM) || (state_d == c_ST_SCAN);
            if (w_acc_clear) begin
                count_q <= '0;
                for (int i = 0; i < OUT_DIM; i++) begin
                    acc_q[i] <= '0;
                end
            end else if (w_acc_en) begin
                count_q <= count_q + CNT_BW'(1);
                for (int i = 0; i < OUT_DIM; i++) begin
                    acc_q[i] <= acc_q[i]
                              + ACC_BW'(in_data_i[i*OUTPUT_BITLENGTH +: OUTPUT_BITLENGTH]);
                end
            end
            if (w_last_sample) begin
                scan_idx_q <= '0;
            end else if (w_scan_en && !w_latch) begin
                scan_idx_q <= scan_idx_q + IDX_BW'(1);
            end
            if (w_latch) begin
                out_valid_q <= 1'b1;
                class_idx_q <= w_take ? scan_idx_q : w_best_idx;
                best_sum_q  <= w_take ? w_scan_val : w_best;
            end else if (w_handshake) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    for (genvar g = 0; g < OUT_DIM; g++) begin : g_pack
        assign acc_out_o[g*ACC_BW +: ACC_BW] = acc_q[g];
    end

    assign busy_o      = busy_q;
    assign out_valid_o = out_valid_q;
    assign class_idx_o = class_idx_q;
    assign best_sum_o  = best_sum_q;

endmodule : rbm_sample_accumulator
`default_nettype wire

// File: tb/tb_rbm_sample_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : tb_rbm_sample_accumulator
// Brief    : Directed scoreboard bench for rbm_sample_accumulator.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rbm_sample_accumulator;

    localparam int OB  = 12;
    localparam int OD  = 5;
    localparam int NS  = 4;
    localparam int ABW = 14;
    localparam int IBW = 3;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               start;
    logic               in_valid;
    logic [OD*OB-1:0]   in_data;
    logic               out_ready;
    logic               busy;
    logic               out_valid;
    logic [IBW-1:0]     class_idx;
    logic [ABW-1:0]     best_sum;
    logic [OD*ABW-1:0]  acc_out;

    rbm_sample_accumulator #(
        .OUTPUT_BITLENGTH (OB),
        .OUT_DIM          (OD),
        .NUM_SAMPLES      (NS)
    ) dut (
        .clock_i     (clk),
        .reset_ni    (rst_n),
        .start_i     (start),
        .in_valid_i  (in_valid),
        .in_data_i   (in_data),
        .out_ready_i (out_ready),
        .busy_o      (busy),
        .out_valid_o (out_valid),
        .class_idx_o (class_idx),
        .best_sum_o  (best_sum),
        .acc_out_o   (acc_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [IBW-1:0]    idx;
        logic [ABW-1:0]    best;
        logic [OD*ABW-1:0] acc;
        int                cyc;
    } exp_t;

    exp_t              sb[$];
    int                checks   = 0;
    int                failures = 0;
    int                cyc      = 0;
    logic              prev_ov  = 1'b0;
    logic [IBW-1:0]    e_idx;
    logic [ABW-1:0]    e_best;
    logic [OD*ABW-1:0] e_acc;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare each published result against the oldest expectation.
    always @(negedge clk) begin
        if (out_valid && !prev_ov) begin
            if (sb.size() == 0) begin
                chk("unexpected_result", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("class_idx", class_idx, e.idx);
                chk("best_sum", best_sum, e.best);
                chk("acc_out", acc_out, e.acc);
                chk("latency_cycle", cyc, e.cyc);
            end
        end
        prev_ov <= out_valid;
    end

    task automatic run(input logic [OD*OB-1:0] smp, input int gap, input bit noise, input bit hold);
        int last;
        int v;
        out_ready = !hold;
        if (noise) begin
            repeat (3) begin
                in_valid = 1'b1;
                in_data  = (OD*OB)'({$urandom(), $urandom()});
                tick();
            end
            in_valid = 1'b0;
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        for (int s = 0; s < NS; s++) begin
            in_valid = 1'b1;
            in_data  = smp;
            tick();
            last     = cyc;
            in_valid = 1'b0;
            in_data  = (OD*OB)'({$urandom(), $urandom()});
            if (s < NS - 1) repeat (gap) tick();
        end
        e_best = '0;
        e_idx  = '0;
        for (int i = 0; i < OD; i++) begin
            v = NS * int'(smp[i*OB +: OB]);
            e_acc[i*ABW +: ABW] = ABW'(v);
            if (ABW'(v) > e_best) begin
                e_best = ABW'(v);
                e_idx  = IBW'(i);
            end
        end
        sb.push_back('{idx: e_idx, best: e_best, acc: e_acc, cyc: last + OD});
        for (int k = 0; k < 40 && !out_valid; k++) tick();
        chk("out_valid_timeout", out_valid, 1);
        if (hold) begin
            for (int k = 0; k < 10; k++) begin
                start = k[0];
                tick();
                chk("hold_valid", out_valid, 1);
                chk("hold_busy", busy, 0);
                chk("hold_idx", class_idx, e_idx);
                chk("hold_best", best_sum, e_best);
            end
            chk("hold_acc", acc_out, e_acc);
            start     = 1'b0;
            out_ready = 1'b1;
            tick();
            chk("valid_drop_after_hs", out_valid, 0);
        end else begin
            tick();
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        in_data   = '0;
        for (int k = 0; k < 2; k++) begin
            start     = 1'($urandom());
            in_valid  = 1'($urandom());
            out_ready = 1'($urandom());
            in_data   = (OD*OB)'({$urandom(), $urandom()});
            tick();
        end
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_class_idx", class_idx, 0);
        chk("rst_best_sum", best_sum, 0);
        chk("rst_acc_out", acc_out, 0);
        rst_n     = 1'b1;
        start     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();

        run({12'd5, 12'd4, 12'd3, 12'd2, 12'd1}, 0, 1'b0, 1'b0);
        run({12'd5, 12'd4, 12'd3, 12'd2, 12'd1}, 3, 1'b1, 1'b0);
        run({12'd0, 12'hFFF, 12'd0, 12'hFFF, 12'd0}, 0, 1'b0, 1'b0);
        chk("tie_best_value", best_sum, 14'h3FFC);
        run({12'd9, 12'd30, 12'd30, 12'd2, 12'd17}, 1, 1'b0, 1'b1);
        run({12'd6, 12'd1, 12'd0, 12'd0, 12'd3}, 0, 1'b0, 1'b0);

        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (2) begin
            in_valid = 1'b1;
            in_data  = {OD{12'h100}};
            tick();
        end
        in_valid = 1'b0;
        rst_n    = 1'b0;
        tick();
        rst_n    = 1'b1;
        chk("midrst_busy", busy, 0);
        chk("midrst_acc", acc_out, 0);
        chk("midrst_valid", out_valid, 0);
        run({12'd0, 12'd0, 12'd7, 12'd0, 12'd0}, 0, 1'b0, 1'b0);
        chk("midrst_run_idx", class_idx, 2);
        chk("midrst_run_best", best_sum, 28);

        repeat (3) tick();
        chk("scoreboard_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule : tb_rbm_sample_accumulator
`default_nettype wire
